cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates the instruction cache and data cache fill/writeback requests onto the single shared RAM port. It sits between the `icache`/`dcache` pair and the memory controller. Each requester sees a wait/load handshake, and the RAM sees one enable/address/store bundle at a time. Dcache is favoured, and a bounded-streak rule prevents icache starvation.

## Interface
Parameters:
- `MAX_DSTREAK`, default 4, range 1..15: consecutive dcache grants allowed while icache is pending before icache is forced.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iwait`  out  1  low for exactly the cycle the icache read completes.
- `iload`  out  32  read data, valid when `iwait`=0.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache address.
- `dstore`  in  32  dcache write data.
- `dwait`  out  1  low for exactly the cycle the dcache access completes.
- `dload`  out  32  read data, valid when `dwait`=0.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: `FREE`=0, `BUSY`=1, `ACCESS`=2, `ERROR`=3.
- `ram_err`  out  1  sticky; set on any `ERROR` response; cleared only by reset.

## Operation
- FSM states: `IDLE`, `IGRANT`, `DGRANT`.
- `IDLE` selection, based on requests sampled in that cycle:
  - Dcache request (`dREN|dWEN`) and no forced icache grant: go to `DGRANT`.
  - Otherwise, if `iREN` is set: go to `IGRANT`.
  - Otherwise: stay in `IDLE`.
- Forced icache: if `iREN` is set and `dstreak`==`MAX_DSTREAK`, go to `IGRANT` even when dcache is requesting.
- `dstreak` (4-bit counter) update:
  - Increments on each `DGRANT` completion when `iREN` was high during that grant.
  - Clears on any `IGRANT` completion.
  - Clears when a `DGRANT` completes with `iREN` low.
  - Saturates at `MAX_DSTREAK`.
- `IGRANT` drives:
  - `ramREN`=1, `ramaddr`=`iaddr`.
- `DGRANT` drives:
  - `ramaddr`=`daddr`, `ramstore`=`dstore`.
  - If `dWEN` is set, `ramWEN`=1 and `ramREN`=0; `dWEN` wins if both `dREN` and `dWEN` are high.
  - Otherwise `ramREN`=1.
- Completion (`ramstate`==`ACCESS` while granted):
  - The granted wait goes low combinationally in that cycle.
  - The granted load equals `ramload`.
  - Next state is `IDLE`.
- `ERROR` while granted: wait stays high, `ram_err` is set, next state is `IDLE`, and the requester retries naturally.
- Request dropped while granted: RAM enables deassert that cycle, wait stays high, next state is `IDLE`.
- The ungranted side always has wait=1 and load=0.
- In `IDLE`, all RAM outputs are 0.

## Timing
- Reset values:
  - `state`=`IDLE`, `dstreak`=0, `ram_err`=0.
  - `iwait`=`dwait`=1, `iload`=`dload`=0.
  - `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
- Minimum latency, request to wait-low: 2 cycles (1 arbitration cycle in `IDLE`, plus a grant cycle with zero-wait RAM). Add one cycle per `BUSY` cycle.
- Back-to-back: after completion, one `IDLE` cycle always precedes the next grant.
- Requesters hold request, address and data stable until their wait is low. The arbiter does not latch them.
- Reset mid-grant: the next edge forces `IDLE` with reset outputs. No partial RAM write is guaranteed beyond the current cycle.
- Simultaneous `iREN` and dcache request in `IDLE` with `dstreak`<`MAX_DSTREAK`: dcache wins.

## Configuration
- `ARB_PERF_CNT_EN` defined: adds outputs `igrant_cnt` (32), `dgrant_cnt` (32) and `stall_cnt` (32).
  - `igrant_cnt` and `dgrant_cnt` count completions.
  - `stall_cnt` counts cycles with any request pending and the wait high.
  - All three reset to 0 and wrap at 2^32.
- Not defined: these ports and counters are absent, and behaviour is otherwise identical.

## Structure
- `cpu_types_pkg` holds:
  - the `ramstate_t` enum (`FREE`/`BUSY`/`ACCESS`/`ERROR`);
  - `word_t` (32-bit);
  - the new `arb_state_t` enum (`IDLE`/`IGRANT`/`DGRANT`).
- Single module, no sub-module. The optional counters sit in one guarded block.

## Test plan
- Icache read only, addr 0x40, `ramstate` = `BUSY` for 2 cycles then `ACCESS`, `ramload`=0xDEADBEEF:
  - `ramREN`=1 from cycle 1;
  - `iwait`=0 with `iload`=0xDEADBEEF in cycle 3;
  - `IDLE` in cycle 4.
- Dcache write, addr 0x80, data 0x12345678, zero-wait RAM: `ramWEN`=1, `ramaddr`=0x80, `ramstore`=0x12345678, `dwait`=0 in cycle 1.
- Both requesting continuously, `MAX_DSTREAK`=4, zero-wait RAM: grant order is D,D,D,D,I,D,D,D,D,I…
- `ERROR` during `DGRANT`: `dwait` stays 1, `ram_err`=1, return to `IDLE`; the request is re-granted on the following cycle.
- `RST` asserted during `IGRANT` with `ramstate`=`BUSY`: next cycle all outputs are at reset values, `iwait`=1, `state`=`IDLE`.
- With `ARB_PERF_CNT_EN`: 3 icache and 2 dcache completions with 5 total wait-high cycles give `igrant_cnt`=3, `dgrant_cnt`=2, `stall_cnt`=5.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the cache/memory path.
// Holds the RAM status encoding, the machine word type and the
// arbiter state encoding used by cache_mem_arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM controller status as reported on ramstate.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter grant states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port between the icache and the dcache.
// Dcache requests win by default. After MAX_DSTREAK back-to-back dcache
// grants taken while the icache was waiting, the icache is served next.
// Every grant is preceded by one IDLE arbitration cycle. Requesters hold
// their request, address and data until their wait goes low, so nothing
// is latched here. All outputs are decoded combinationally from the state.
// Optional: define ARB_PERF_CNT_EN to add grant and stall counters.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  word_t       iaddr,
  output logic        iwait,
  output word_t       iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output logic        dwait,
  output word_t       dload,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
`ifdef ARB_PERF_CNT_EN
  ,
  output word_t       igrant_cnt,
  output word_t       dgrant_cnt,
  output word_t       stall_cnt
`endif
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  arb_state_t state, state_next;
  logic [3:0] dstreak, dstreak_next;
  ramstate_t  rs;
  logic       dreq;
  logic       force_i;
  logic       i_done;
  logic       d_done;
  logic       err_hit;

  assign rs      = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  assign force_i = iREN && (dstreak == STREAK_MAX);

  // Next-state selection and RAM/requester output decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next = state;
    iwait      = 1'b1;
    iload      = '0;
    dwait      = 1'b1;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    err_hit    = 1'b0;

    case (state)
      IDLE: begin
        if (dreq && !force_i) begin
          state_next = DGRANT;
        end else if (iREN) begin
          state_next = IGRANT;
        end
      end

      IGRANT: begin
        if (!iREN) begin
          // Request withdrawn: leave the RAM untouched and rearbitrate.
          state_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          case (rs)
            ACCESS: begin
              iwait      = 1'b0;
              iload      = ramload;
              i_done     = 1'b1;
              state_next = IDLE;
            end
            ERROR: begin
              err_hit    = 1'b1;
              state_next = IDLE;
            end
            default: ;
          endcase
        end
      end

      DGRANT: begin
        if (!dreq) begin
          state_next = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          // A write takes precedence when both enables are raised.
          if (dWEN) begin
            ramWEN = 1'b1;
          end else begin
            ramREN = 1'b1;
          end
          case (rs)
            ACCESS: begin
              dwait      = 1'b0;
              dload      = ramload;
              d_done     = 1'b1;
              state_next = IDLE;
            end
            ERROR: begin
              err_hit    = 1'b1;
              state_next = IDLE;
            end
            default: ;
          endcase
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Dcache streak: counts dcache completions taken while the icache waits.
  always_comb begin
    dstreak_next = dstreak;
    if (i_done) begin
      dstreak_next = '0;
    end else if (d_done) begin
      if (!iREN) begin
        dstreak_next = '0;
      end else if (dstreak != STREAK_MAX) begin
        dstreak_next = dstreak + 4'd1;
      end
    end
  end

  // State, streak counter and sticky error flag.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state   <= IDLE;
      dstreak <= '0;
      ram_err <= 1'b0;
    end else begin
      state   <= state_next;
      dstreak <= dstreak_next;
      ram_err <= ram_err | err_hit;
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Completion counts per requester and cycles spent waiting on the RAM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      igrant_cnt <= '0;
      dgrant_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (i_done) igrant_cnt <= igrant_cnt + 32'd1;
      if (d_done) dgrant_cnt <= dgrant_cnt + 32'd1;
      if ((iREN && iwait) || (dreq && dwait)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter.
// The bench plays both caches and the RAM. Each issued request pushes its
// expected response; a monitor pops and compares on every wait-low cycle.
// Define ARB_PERF_CNT_EN to also compare the performance counters.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAX_DSTREAK = 4;
  localparam int TIMEOUT     = 200;

  logic       CLK = 1'b0;
  logic       RST;
  logic       iREN;
  word_t      iaddr;
  logic       iwait;
  word_t      iload;
  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  logic       dwait;
  word_t      dload;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  logic [1:0] ramstate;
  logic       ram_err;
`ifdef ARB_PERF_CNT_EN
  word_t      igrant_cnt;
  word_t      dgrant_cnt;
  word_t      stall_cnt;
`endif

  cache_mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
`ifdef ARB_PERF_CNT_EN
    , .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    word_t addr;
    word_t data;
    logic  wr;
    word_t store;
  } txn_t;

  int    checks = 0;
  int    errors = 0;
  txn_t  i_q[$];
  txn_t  d_q[$];
  txn_t  mon_t;
  bit    order[$];
  bit    order_en = 0;
  bit    mon_en = 0;
  word_t ram_mem[256];
  word_t ref_mem[256];
  bit    i_pend = 0, d_pend = 0, i_done = 0, d_done = 0;
  int    i_age = 0, d_age = 0;
  int    busy_fixed = -1;
  int    err_pct = 0;
  int    busy_cnt = 0, busy_target = 0;
  bit    err_exp = 0, err_pending = 0;
  int    m_icnt = 0, m_dcnt = 0, m_stall = 0;

  assign ramload = ram_mem[ramaddr[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // RAM model (status and writes) plus the scoreboard monitor.
  initial begin
    ramstate = FREE;
    forever begin
      @(posedge CLK);
      if (RST) begin
        err_exp = 0;
        m_icnt = 0; m_dcnt = 0; m_stall = 0;
      end else if (err_pending) begin
        err_exp = 1;
      end
      err_pending = 0;
      #2;
      if (ramREN || ramWEN) begin
        if (busy_cnt < busy_target) begin
          ramstate = BUSY;
          busy_cnt++;
        end else begin
          if ($urandom_range(0, 99) < err_pct) begin
            ramstate = ERROR;
            err_pending = 1;
          end else begin
            ramstate = ACCESS;
          end
          busy_cnt = 0;
          busy_target = (busy_fixed >= 0) ? busy_fixed : $urandom_range(0, 2);
        end
      end else begin
        ramstate = FREE;
        busy_cnt = 0;
        busy_target = (busy_fixed >= 0) ? busy_fixed : $urandom_range(0, 2);
      end

      @(negedge CLK);
      if (mon_en) begin
        check("ram_err", ram_err, err_exp);
        if (iwait) check("iload idle", iload, 32'h0);
        if (dwait) check("dload idle", dload, 32'h0);
        if ((iREN && iwait) || ((dREN || dWEN) && dwait)) m_stall++;
        if (!iwait) begin
          if (i_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL icache completion: got unexpected completion at 0x%08h, expected none", ramaddr);
          end else begin
            mon_t = i_q.pop_front();
            check("iload", iload, mon_t.data);
            check("i ramaddr", ramaddr, mon_t.addr);
            check("i ramREN", {31'b0, ramREN}, 32'h1);
          end
          i_done = 1;
          m_icnt++;
          if (order_en) order.push_back(1'b0);
        end
        if (!dwait) begin
          if (d_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dcache completion: got unexpected completion at 0x%08h, expected none", ramaddr);
          end else begin
            mon_t = d_q.pop_front();
            check("dload", dload, mon_t.data);
            check("d ramaddr", ramaddr, mon_t.addr);
            check("d ramWEN", {31'b0, ramWEN}, {31'b0, mon_t.wr});
            check("d ramREN", {31'b0, ramREN}, {31'b0, ~mon_t.wr});
            if (mon_t.wr) check("d ramstore", ramstore, mon_t.store);
          end
          d_done = 1;
          m_dcnt++;
          if (order_en) order.push_back(1'b1);
        end
        if (!iwait && !dwait) begin
          checks++; errors++;
          $display("FAIL both waits low: got iwait=0 dwait=0, expected at most one low");
        end
      end
      if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr[7:0]] = ramstore;
    end
  end

  // One clock: retire completed requests and age pending ones.
  task automatic tick();
    @(posedge CLK); #1;
    if (i_done) begin i_done = 0; i_pend = 0; iREN = 0; end
    if (d_done) begin d_done = 0; d_pend = 0; dREN = 0; dWEN = 0; end
    if (i_pend && ++i_age > TIMEOUT) begin
      checks++; errors++;
      $display("FAIL icache timeout: waited %0d cycles, limit %0d", i_age, TIMEOUT);
      i_pend = 0; iREN = 0; i_q.delete();
    end
    if (d_pend && ++d_age > TIMEOUT) begin
      checks++; errors++;
      $display("FAIL dcache timeout: waited %0d cycles, limit %0d", d_age, TIMEOUT);
      d_pend = 0; dREN = 0; dWEN = 0; d_q.delete();
    end
  endtask

  task automatic issue_i(input word_t a);
    iaddr = a; iREN = 1; i_pend = 1; i_age = 0;
    i_q.push_back('{addr: a, data: ref_mem[a[7:0]], wr: 1'b0, store: 32'h0});
  endtask

  task automatic issue_d(input word_t a, input bit wr, input word_t data, input bit both);
    daddr = a; dstore = data; d_pend = 1; d_age = 0;
    d_q.push_back('{addr: a, data: ref_mem[a[7:0]], wr: wr, store: data});
    if (wr) begin
      ref_mem[a[7:0]] = data;
      dWEN = 1; dREN = both;
    end else begin
      dWEN = 0; dREN = 1;
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((i_pend || d_pend) && n < limit) begin tick(); n++; end
    if (i_pend || d_pend) begin
      checks++; errors++;
      $display("FAIL drain: got requests pending after %0d cycles, expected none", limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " iwait"}, {31'b0, iwait}, 32'h1);
    check({tag, " dwait"}, {31'b0, dwait}, 32'h1);
    check({tag, " iload"}, iload, 32'h0);
    check({tag, " dload"}, dload, 32'h0);
    check({tag, " ramREN"}, {31'b0, ramREN}, 32'h0);
    check({tag, " ramWEN"}, {31'b0, ramWEN}, 32'h0);
    check({tag, " ramaddr"}, ramaddr, 32'h0);
    check({tag, " ramstore"}, ramstore, 32'h0);
    check({tag, " ram_err"}, {31'b0, ram_err}, 32'h0);
  endtask

  initial begin
    word_t a;
    RST = 1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    for (int i = 0; i < 256; i++) begin
      a = $urandom;
      ram_mem[i] = a;
      ref_mem[i] = a;
    end
    ram_mem[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;

    // Reset values.
    tick(); tick();
    @(negedge CLK);
    check_reset_outputs("reset");
    tick(); RST = 0; mon_en = 1;

    // Both caches request continuously with a zero-wait RAM.
    busy_fixed = 0; order_en = 1;
    issue_i(32'h0000_0010);
    issue_d(32'h0000_0090, 1'b0, 32'h0, 1'b0);
    repeat (60) begin
      tick();
      if (!i_pend) issue_i(32'($urandom_range(0, 127)));
      if (!d_pend) issue_d(32'($urandom_range(128, 255)), 1'b0, 32'h0, 1'b0);
    end
    order_en = 0;
    drain(50);
    if (order.size() < 10) begin
      checks++; errors++;
      $display("FAIL grant order: got %0d grants, expected at least 10", order.size());
    end else begin
      for (int k = 0; k < 10; k++)
        check($sformatf("grant order %0d", k), {31'b0, order[k]}, (k % (MAX_DSTREAK + 1) == MAX_DSTREAK) ? 32'h0 : 32'h1);
    end

    // Icache read with two BUSY cycles.
    busy_fixed = 2;
    tick(); issue_i(32'h40);
    @(negedge CLK); check("c0 ramREN", {31'b0, ramREN}, 32'h0);
    tick(); @(negedge CLK);
    check("c1 ramREN", {31'b0, ramREN}, 32'h1);
    check("c1 ramaddr", ramaddr, 32'h40);
    check("c1 iwait", {31'b0, iwait}, 32'h1);
    tick(); @(negedge CLK); check("c2 iwait", {31'b0, iwait}, 32'h1);
    tick(); @(negedge CLK);
    check("c3 iwait", {31'b0, iwait}, 32'h0);
    check("c3 iload", iload, 32'hDEADBEEF);
    tick(); @(negedge CLK);
    check("c4 ramREN", {31'b0, ramREN}, 32'h0);
    check("c4 iwait", {31'b0, iwait}, 32'h1);

    // Dcache write, zero-wait RAM, both enables raised.
    busy_fixed = 0;
    tick(); issue_d(32'h80, 1'b1, 32'h12345678, 1'b1);
    tick(); @(negedge CLK);
    check("wr ramWEN", {31'b0, ramWEN}, 32'h1);
    check("wr ramREN", {31'b0, ramREN}, 32'h0);
    check("wr ramaddr", ramaddr, 32'h80);
    check("wr ramstore", ramstore, 32'h12345678);
    check("wr dwait", {31'b0, dwait}, 32'h0);
    tick();

    // ERROR during a dcache grant, then retry.
    err_pct = 100;
    tick(); issue_d(32'h84, 1'b0, 32'h0, 1'b0);
    tick(); @(negedge CLK);
    check("err dwait", {31'b0, dwait}, 32'h1);
    check("err ramREN", {31'b0, ramREN}, 32'h1);
    err_pct = 0;
    tick(); @(negedge CLK);
    check("err idle ramREN", {31'b0, ramREN}, 32'h0);
    check("err sticky", {31'b0, ram_err}, 32'h1);
    tick(); @(negedge CLK);
    check("retry ramREN", {31'b0, ramREN}, 32'h1);
    check("retry dwait", {31'b0, dwait}, 32'h0);
    tick();

    // Reset in the middle of a BUSY icache grant.
    busy_fixed = 10;
    tick(); issue_i(32'h44);
    tick(); @(negedge CLK); check("rst c1 ramREN", {31'b0, ramREN}, 32'h1);
    tick(); RST = 1;
    @(negedge CLK); check("rst c2 iwait", {31'b0, iwait}, 32'h1);
    tick(); RST = 0; iREN = 0; i_pend = 0; i_q.delete();
    @(negedge CLK);
    check_reset_outputs("midgrant");

    // Randomised traffic with BUSY stretches and occasional ERRORs.
    busy_fixed = -1; err_pct = 10;
    repeat (1500) begin
      tick();
      if (!i_pend && $urandom_range(0, 99) < 40) begin
        a = $urandom; a[7] = 1'b0;
        issue_i(a);
      end
      if (!d_pend && $urandom_range(0, 99) < 50) begin
        a = $urandom; a[7] = 1'b1;
        issue_d(a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
    end
    drain(TIMEOUT);
    for (int i = 128; i < 256; i++)
      check($sformatf("mem[%0d]", i), ram_mem[i], ref_mem[i]);

`ifdef ARB_PERF_CNT_EN
    tick(); @(negedge CLK);
    check("igrant_cnt", igrant_cnt, 32'(m_icnt));
    check("dgrant_cnt", dgrant_cnt, 32'(m_dcnt));
    check("stall_cnt", stall_cnt, 32'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
